// File: rtl/inst_rom_loader_pkg.sv
// Shared constants for the instruction ROM and its byte-stream loader.
// State encodings, NOP word and big-endian byte-lane helpers.
package inst_rom_loader_pkg;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } ld_state_e;

  localparam logic [1:0] LANE_FIRST = 2'd0;
  localparam logic [1:0] LANE_LAST  = 2'd3;

  // Lane 0 is the most significant byte of the word.
  function automatic logic [31:0] lane_put(
    input logic [1:0] lane,
    input logic [7:0] b
  );
    logic [4:0] sh;
    sh = 5'd24 - {lane, 3'b000};
    return {24'h0, b} << sh;
  endfunction

endpackage

// File: rtl/inst_rom_loader_if.sv
// Valid/ready byte-stream link from the image source to the ROM loader.
// The master drives bytes; the slave answers with ld_ready.
interface inst_rom_loader_if;

  logic       ld_start;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_last;
  logic       ld_ready;

  modport master (
    output ld_start,
    output ld_valid,
    output ld_data,
    output ld_last,
    input  ld_ready
  );

  modport slave (
    input  ld_start,
    input  ld_valid,
    input  ld_data,
    input  ld_last,
    output ld_ready
  );

endinterface

// File: rtl/inst_rom_loader_rom_byte_packer.sv
// Packs accepted loader bytes big-endian into 32-bit words.
// Emits a word strobe on the 4th byte or on a last byte.
module rom_byte_packer
  import inst_rom_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        acc,
  input  logic [7:0]  data,
  input  logic        last,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  cnt_q;
  logic [31:0] sh_q;

  // Unfilled low lanes are still zero, which pads a short word.
  assign word = sh_q | lane_put(cnt_q, data);
  assign word_valid = acc && (cnt_q == LANE_LAST || last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= LANE_FIRST;
      sh_q  <= NOP;
    end else if (clr) begin
      cnt_q <= LANE_FIRST;
      sh_q  <= NOP;
    end else if (acc) begin
      if (word_valid) begin
        cnt_q <= LANE_FIRST;
        sh_q  <= NOP;
      end else begin
        cnt_q <= cnt_q + 2'd1;
        sh_q  <= word;
      end
    end
  end

endmodule

// File: rtl/inst_rom_loader.sv
// Instruction ROM with combinational fetch port and byte-stream loader.
// Holds the CPU in reset until a complete image has been written.
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_ce,
  input  logic [31:0]       rom_addr,
  output logic [31:0]       rom_data,
  output logic              cpu_rst_o,
  inst_rom_loader_if.slave  ld,
  output logic [ADDR_W:0]   load_words_o,
  output logic              overflow_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  ld_state_e       state_q;
  ld_state_e       state_d;
  logic            ready_q;
  logic [ADDR_W:0] words_q;
  logic            ovf_q;
  logic            acc;
  logic            full;
  logic [31:0]     word;
  logic            word_valid;
  logic            in_range;
  logic [1:0]      unused_lsb;
  logic [31:0]     mem [DEPTH];

  assign ld.ld_ready = ready_q & ~ld.ld_start;
  assign acc = ld.ld_valid & ld.ld_ready;
  assign full = words_q[ADDR_W];

  rom_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (ld.ld_start),
    .acc        (acc),
    .data       (ld.ld_data),
    .last       (ld.ld_last),
    .word       (word),
    .word_valid (word_valid)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD: begin
        if (!ld.ld_start && acc && ld.ld_last)
          state_d = RUN;
      end
      RUN: begin
        if (ld.ld_start)
          state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOAD;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == LOAD);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      words_q <= '0;
      ovf_q   <= 1'b0;
    end else if (ld.ld_start) begin
      words_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (word_valid && !full)
        words_q <= words_q + 1'b1;
      if (acc && full)
        ovf_q <= 1'b1;
    end
  end

  // Array is deliberately not reset so a warm reset keeps the image.
  always_ff @(posedge clk) begin
    if (word_valid && !full)
      mem[words_q[ADDR_W-1:0]] <= word;
  end

  assign in_range = (rom_addr >> (ADDR_W + 2)) == 32'h0;
  assign unused_lsb = rom_addr[1:0];

  assign rom_data =
    (rom_ce && state_q == RUN && in_range)
      ? mem[rom_addr[ADDR_W+1:2]] : NOP;

  assign cpu_rst_o = (state_q == LOAD);
  assign load_words_o = words_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed self-checking bench for inst_rom_loader.
// Two instances: ADDR_W=10 for function, ADDR_W=2 for overflow.
module tb_inst_rom_loader;

  typedef struct {
    logic [7:0]  d;
    logic        l;
    logic [10:0] w;
    logic        cr;
  } bv_t;

  typedef struct {
    logic        ce;
    logic [31:0] a;
    logic [31:0] exp;
  } rv_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce1 = 1'b0;
  logic        ce2 = 1'b0;
  logic [31:0] a1 = 32'h0;
  logic [31:0] a2 = 32'h0;
  logic [31:0] d1;
  logic [31:0] d2;
  logic        cr1;
  logic        cr2;
  logic [10:0] w1;
  logic [2:0]  w2;
  logic        ov1;
  logic        ov2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  inst_rom_loader_if i1 ();
  inst_rom_loader_if i2 ();

  inst_rom_loader #(.ADDR_W(10)) u1 (
    .clk          (clk),
    .rst          (rst),
    .rom_ce       (ce1),
    .rom_addr     (a1),
    .rom_data     (d1),
    .cpu_rst_o    (cr1),
    .ld           (i1),
    .load_words_o (w1),
    .overflow_o   (ov1)
  );

  inst_rom_loader #(.ADDR_W(2)) u2 (
    .clk          (clk),
    .rst          (rst),
    .rom_ce       (ce2),
    .rom_addr     (a2),
    .rom_data     (d2),
    .cpu_rst_o    (cr2),
    .ld           (i2),
    .load_words_o (w2),
    .overflow_o   (ov2)
  );

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic set_in(input int w, input logic v, input logic [7:0] d,
                        input logic l, input logic s);
    if (w == 0) begin
      i1.ld_valid = v; i1.ld_data = d; i1.ld_last = l; i1.ld_start = s;
    end else begin
      i2.ld_valid = v; i2.ld_data = d; i2.ld_last = l; i2.ld_start = s;
    end
  endtask

  function automatic logic rdy(input int w);
    return (w == 0) ? i1.ld_ready : i2.ld_ready;
  endfunction

  task automatic send(input int w, input logic [7:0] d, input logic l);
    int n;
    n = 0;
    @(negedge clk);
    set_in(w, 1'b1, d, l, 1'b0);
    while (!rdy(w) && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (!rdy(w)) check("ready_timeout", 32'(rdy(w)), 32'h1);
    @(posedge clk);
    #1;
    set_in(w, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic pulse_start(input int w);
    @(negedge clk);
    set_in(w, 1'b0, 8'h00, 1'b0, 1'b1);
    #1;
    check("start_ready_low", 32'(rdy(w)), 32'h0);
    @(posedge clk);
    #1;
    set_in(w, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bv_t img[8];
    rv_t rd[5];
    rv_t rd2[5];

    img[0] = '{8'h3C, 1'b0, 11'd0, 1'b1};
    img[1] = '{8'h01, 1'b0, 11'd0, 1'b1};
    img[2] = '{8'h12, 1'b0, 11'd0, 1'b1};
    img[3] = '{8'h34, 1'b0, 11'd1, 1'b1};
    img[4] = '{8'h00, 1'b0, 11'd1, 1'b1};
    img[5] = '{8'h00, 1'b0, 11'd1, 1'b1};
    img[6] = '{8'h00, 1'b0, 11'd1, 1'b1};
    img[7] = '{8'h00, 1'b1, 11'd2, 1'b0};

    rd[0] = '{1'b1, 32'h0000_0000, 32'h3C01_1234};
    rd[1] = '{1'b1, 32'h0000_0004, 32'h0000_0000};
    rd[2] = '{1'b1, 32'h0000_0003, 32'h3C01_1234};
    rd[3] = '{1'b0, 32'h0000_0000, 32'h0000_0000};
    rd[4] = '{1'b1, 32'h0000_1000, 32'h0000_0000};

    rd2[0] = '{1'b1, 32'h0000_0000, 32'h0102_0304};
    rd2[1] = '{1'b1, 32'h0000_0004, 32'h0506_0708};
    rd2[2] = '{1'b1, 32'h0000_0008, 32'h090A_0B0C};
    rd2[3] = '{1'b1, 32'h0000_000C, 32'h0D0E_0F10};
    rd2[4] = '{1'b1, 32'h0000_0010, 32'h0000_0000};

    set_in(0, 1'b0, 8'h00, 1'b0, 1'b0);
    set_in(1, 1'b0, 8'h00, 1'b0, 1'b0);

    #2 rst = 1'b0;
    #1;
    check("rst_cpu_rst", 32'(cr1), 32'h1);
    check("rst_ready", 32'(i1.ld_ready), 32'h0);
    check("rst_words", 32'(w1), 32'h0);
    check("rst_ovf", 32'(ov1), 32'h0);
    check("rst_ovf2", 32'(ov2), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rel", 32'(i1.ld_ready), 32'h1);

    for (int i = 0; i < 8; i++) begin
      send(0, img[i].d, img[i].l);
      check("img_words", 32'(w1), 32'(img[i].w));
      check("img_cpu_rst", 32'(cr1), 32'(img[i].cr));
    end
    check("run_ready_low", 32'(i1.ld_ready), 32'h0);

    for (int i = 0; i < 5; i++) begin
      ce1 = rd[i].ce;
      a1 = rd[i].a;
      #1;
      check("read_tbl", d1, rd[i].exp);
    end

    ce1 = 1'b1;
    a1 = 32'h0;
    pulse_start(0);
    check("reload_cpu_rst", 32'(cr1), 32'h1);
    check("reload_words", 32'(w1), 32'h0);
    check("reload_nop", d1, 32'h0);
    send(0, 8'h11, 1'b0);
    send(0, 8'h22, 1'b0);
    send(0, 8'h33, 1'b0);
    send(0, 8'h44, 1'b0);
    check("load_nop", d1, 32'h0);
    send(0, 8'h55, 1'b1);
    check("part_words", 32'(w1), 32'h2);
    check("part_cpu_rst", 32'(cr1), 32'h0);
    a1 = 32'h0;
    #1 check("part_w0", d1, 32'h1122_3344);
    a1 = 32'h4;
    #1 check("part_w1", d1, 32'h5500_0000);

    pulse_start(0);
    for (int i = 0; i < 6; i++)
      send(0, 8'hA0 + 8'(i), 1'b0);
    check("pre_restart_words", 32'(w1), 32'h1);
    @(negedge clk);
    set_in(0, 1'b1, 8'hEE, 1'b0, 1'b1);
    #1 check("restart_ready", 32'(i1.ld_ready), 32'h0);
    @(posedge clk);
    #1;
    set_in(0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("restart_words", 32'(w1), 32'h0);
    check("restart_cpu_rst", 32'(cr1), 32'h1);
    send(0, 8'hC1, 1'b0);
    send(0, 8'hC2, 1'b0);
    send(0, 8'hC3, 1'b0);
    send(0, 8'hC4, 1'b1);
    check("restart_done_words", 32'(w1), 32'h1);
    a1 = 32'h0;
    #1 check("restart_w0", d1, 32'hC1C2_C3C4);
    a1 = 32'h4;
    #1 check("restart_w1_kept", d1, 32'h5500_0000);

    for (int i = 1; i <= 20; i++) begin
      send(1, 8'(i), i == 20);
      check("ovf_words", 32'(w2), (i >= 16) ? 32'd4 : 32'(i / 4));
      check("ovf_flag", 32'(ov2), (i > 16) ? 32'h1 : 32'h0);
      check("ovf_cpu_rst", 32'(cr2), (i == 20) ? 32'h0 : 32'h1);
    end
    for (int i = 0; i < 5; i++) begin
      ce2 = rd2[i].ce;
      a2 = rd2[i].a;
      #1;
      check("ovf_read", d2, rd2[i].exp);
    end
    pulse_start(1);
    check("ovf_clr", 32'(ov2), 32'h0);
    check("ovf_clr_words", 32'(w2), 32'h0);
    check("ovf_clr_cpu_rst", 32'(cr2), 32'h1);

    pulse_start(0);
    for (int i = 0; i < 6; i++)
      send(0, 8'hD0 + 8'(i), 1'b0);
    check("mid_words", 32'(w1), 32'h1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_cpu_rst", 32'(cr1), 32'h1);
    check("arst_words", 32'(w1), 32'h0);
    check("arst_ready", 32'(i1.ld_ready), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    send(0, 8'hE0, 1'b0);
    send(0, 8'hE1, 1'b0);
    send(0, 8'hE2, 1'b0);
    send(0, 8'hE3, 1'b1);
    check("arst_reload_words", 32'(w1), 32'h1);
    a1 = 32'h0;
    #1 check("arst_w0", d1, 32'hE0E1_E2E3);
    a1 = 32'h4;
    #1 check("arst_w1_kept", d1, 32'h5500_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
